// File: rtl/instruction_fetch_queue.sv
// Prefetch FIFO feeding the instruction register. Queued words load into ir one edge after IRWrite,
// and an empty queue can bypass memData straight into ir. mem_ready backpressure comes from registered count only.
module instruction_fetch_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           memData,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic                       IRWrite,
    input  logic                       flush,
    output logic [WIDTH-1:0]           ir,
    output logic [3:0]                 ir_op,
    output logic                       ir_valid,
    output logic                       load_miss,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] fifo_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic             ir_valid_q, ir_valid_d;

    logic empty, push, pop, bypass, miss;

    assign empty  = (count_q == '0);
    assign mem_ready = (count_q != CW'(DEPTH));
    assign bypass = IRWrite && empty && mem_valid && !flush;
    assign push   = mem_valid && mem_ready && !flush && !bypass;
    assign pop    = IRWrite && !empty && !flush;
    assign miss   = IRWrite && empty && !mem_valid && !flush;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            ir_valid_d = 1'b0;
        end else begin
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d     = head_q + PW'(1);
                ir_d       = fifo_q[head_q];
                ir_valid_d = 1'b1;
            end
            if (bypass) begin
                ir_d       = memData;
                ir_valid_d = 1'b1;
            end
            if (miss) begin
                ir_valid_d = 1'b0;
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[tail_q] <= memData;
        end
    end

    // Miss is flagged in the IRWrite cycle itself; held low while in reset.
    assign load_miss = miss && rst_n;
    assign ir        = ir_q;
    assign ir_op     = ir_q[WIDTH-1 -: 4];
    assign ir_valid  = ir_valid_q;
    assign count     = count_q;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: WIDTH16/DEPTH4 and WIDTH32/DEPTH8 instances with an ir-load scoreboard.
module tb_instruction_fetch_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] a_data;
    logic        a_mv, a_irw, a_fl, a_rdy, a_iv, a_miss;
    logic [15:0] a_ir;
    logic [3:0]  a_op;
    logic [2:0]  a_cnt;

    logic [31:0] b_data;
    logic        b_mv, b_irw, b_fl, b_rdy, b_iv, b_miss;
    logic [31:0] b_ir;
    logic [3:0]  b_op;
    logic [3:0]  b_cnt;

    instruction_fetch_queue #(.WIDTH(16), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .memData(a_data), .mem_valid(a_mv), .mem_ready(a_rdy),
        .IRWrite(a_irw), .flush(a_fl), .ir(a_ir), .ir_op(a_op), .ir_valid(a_iv),
        .load_miss(a_miss), .count(a_cnt));

    instruction_fetch_queue #(.WIDTH(32), .DEPTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .memData(b_data), .mem_valid(b_mv), .mem_ready(b_rdy),
        .IRWrite(b_irw), .flush(b_fl), .ir(b_ir), .ir_op(b_op), .ir_valid(b_iv),
        .load_miss(b_miss), .count(b_cnt));

    typedef struct packed {
        logic [31:0] ir;
        logic        vld;
        logic [3:0]  op;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;
    logic pend_a = 1'b0;
    logic pend_b = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] fill_a [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [31:0] fill_b [8] = '{32'h1000_0011, 32'h2000_0022, 32'h3000_0033, 32'h4000_0044,
                                32'h5000_0055, 32'h6000_0066, 32'h7000_0077, 32'h8000_0088};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] v, input logic vld, input logic [3:0] op);
        exp_t e;
        e.ir  = v;
        e.vld = vld;
        e.op  = op;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: an IRWrite seen before an edge resolves into an ir load checked at the following negedge.
    always begin
        @(negedge clk);
        if (pend_a) begin
            if (sb_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL A_load: ir load with no expectation, got %h", a_ir);
            end else begin
                ea = sb_a.pop_front();
                chk("A_ir", 32'(a_ir), ea.ir);
                chk("A_ir_op", 32'(a_op), 32'(ea.op));
                chk("A_ir_valid", 32'(a_iv), 32'(ea.vld));
            end
        end
        pend_a = a_irw && !a_fl && rst_n;
    end

    always begin
        @(negedge clk);
        if (pend_b) begin
            if (sb_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL B_load: ir load with no expectation, got %h", b_ir);
            end else begin
                eb = sb_b.pop_front();
                chk("B_ir", b_ir, eb.ir);
                chk("B_ir_op", 32'(b_op), 32'(eb.op));
                chk("B_ir_valid", 32'(b_iv), 32'(eb.vld));
            end
        end
        pend_b = b_irw && !b_fl && rst_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_data = '0; a_mv = 1'b0; a_irw = 1'b0; a_fl = 1'b0;
        b_data = '0; b_mv = 1'b0; b_irw = 1'b0; b_fl = 1'b0;
        #2;
        chk("rst_count", 32'(a_cnt), 32'd0);
        chk("rst_mem_ready", 32'(a_rdy), 32'd1);
        chk("rst_ir", 32'(a_ir), 32'd0);
        chk("rst_ir_valid", 32'(a_iv), 32'd0);
        chk("rst_load_miss", 32'(a_miss), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // In-order fill to full, overflow word refused, then drain.
        a_mv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = fill_a[i];
            step();
        end
        chk("fill_count", 32'(a_cnt), 32'd4);
        chk("fill_mem_ready", 32'(a_rdy), 32'd0);
        a_data = 16'h5555;
        step();
        chk("overflow_count", 32'(a_cnt), 32'd4);
        a_mv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_irw = 1'b1;
            sb_a.push_back(mk(32'(fill_a[i]), 1'b1, 4'(i + 1)));
            step();
        end
        a_irw = 1'b0;
        chk("drain_count", 32'(a_cnt), 32'd0);

        // Bypass into ir from an empty queue.
        a_mv = 1'b1; a_data = 16'hA123; a_irw = 1'b1;
        sb_a.push_back(mk(32'h0000_A123, 1'b1, 4'hA));
        step();
        a_mv = 1'b0; a_irw = 1'b0;
        chk("bypass_count", 32'(a_cnt), 32'd0);

        // Miss: nothing queued, nothing presented.
        a_irw = 1'b1;
        sb_a.push_back(mk(32'h0000_A123, 1'b0, 4'hA));
        #1;
        chk("miss_pulse", 32'(a_miss), 32'd1);
        step();
        a_irw = 1'b0;
        #1;
        chk("miss_clear", 32'(a_miss), 32'd0);

        // Continuous push and pop at count 2; pointers wrap three times.
        a_mv = 1'b1;
        a_data = 16'hB000; step();
        a_data = 16'hB001; step();
        chk("pp_prefill", 32'(a_cnt), 32'd2);
        for (int i = 0; i < 12; i++) begin
            a_data = 16'(16'hB002 + i);
            a_irw = 1'b1;
            sb_a.push_back(mk(32'(16'hB000 + i), 1'b1, 4'hB));
            step();
            chk("pp_count", 32'(a_cnt), 32'd2);
        end
        a_mv = 1'b0;
        for (int i = 12; i < 14; i++) begin
            sb_a.push_back(mk(32'(16'hB000 + i), 1'b1, 4'hB));
            step();
        end
        a_irw = 1'b0;
        chk("pp_drain", 32'(a_cnt), 32'd0);

        // Flush wins over a simultaneous push and IRWrite.
        a_mv = 1'b1;
        a_data = 16'hC001; step();
        a_data = 16'hC002; step();
        a_data = 16'hC003; step();
        chk("flush_pre", 32'(a_cnt), 32'd3);
        a_data = 16'hC0FF; a_irw = 1'b1; a_fl = 1'b1;
        step();
        a_fl = 1'b0; a_irw = 1'b0; a_mv = 1'b0;
        chk("flush_count", 32'(a_cnt), 32'd0);
        chk("flush_ir_valid", 32'(a_iv), 32'd0);
        chk("flush_ir", 32'(a_ir), 32'h0000_B00D);
        chk("flush_mem_ready", 32'(a_rdy), 32'd1);
        a_irw = 1'b1;
        sb_a.push_back(mk(32'h0000_B00D, 1'b0, 4'hB));
        #1;
        chk("flush_dropped", 32'(a_miss), 32'd1);
        step();
        a_irw = 1'b0;

        // Asynchronous reset between edges with three words queued.
        a_mv = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_data = 16'(16'hD000 + i);
            step();
        end
        a_mv = 1'b0; a_irw = 1'b1;
        sb_a.push_back(mk(32'h0000_D001, 1'b1, 4'hD));
        step();
        a_irw = 1'b0;
        chk("arst_pre", 32'(a_cnt), 32'd3);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(a_cnt), 32'd0);
        chk("arst_mem_ready", 32'(a_rdy), 32'd1);
        chk("arst_ir", 32'(a_ir), 32'd0);
        chk("arst_ir_valid", 32'(a_iv), 32'd0);
        chk("arst_load_miss", 32'(a_miss), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("arst_release_count", 32'(a_cnt), 32'd0);

        // Fill test on the WIDTH=32, DEPTH=8 instance.
        b_mv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_data = fill_b[i];
            step();
        end
        chk("B_fill_count", 32'(b_cnt), 32'd8);
        chk("B_fill_mem_ready", 32'(b_rdy), 32'd0);
        b_data = 32'h9999_9999;
        step();
        chk("B_overflow_count", 32'(b_cnt), 32'd8);
        b_mv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_irw = 1'b1;
            sb_b.push_back(mk(fill_b[i], 1'b1, 4'(i + 1)));
            step();
        end
        b_irw = 1'b0;
        chk("B_drain_count", 32'(b_cnt), 32'd0);

        step(); step();
        chk("A_scoreboard_drained", 32'(sb_a.size()), 32'd0);
        chk("B_scoreboard_drained", 32'(sb_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning instruction word width in bits, a multiple of 4 and at least 8.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning prefetch queue entries, a power of 2 and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port memData, input, WIDTH bits: fetched instruction word.
REQ-006 The block SHALL have port mem_valid, input, 1 bit: memData holds a valid word.
REQ-007 The block SHALL have port mem_ready, output, 1 bit: queue accepts a word this cycle.
REQ-008 The block SHALL have port IRWrite, input, 1 bit: request to load the next instruction into the IR.
REQ-009 The block SHALL have port flush, input, 1 bit: discard all queued words, for example on a branch.
REQ-010 The block SHALL have port ir, output, WIDTH bits: current instruction register value.
REQ-011 The block SHALL have port ir_op, output, 4 bits: ir[WIDTH-1:WIDTH-4], the opcode field.
REQ-012 The block SHALL have port ir_valid, output, 1 bit: ir holds an instruction loaded by the most recent IRWrite.
REQ-013 The block SHALL have port load_miss, output, 1 bit: one-cycle pulse when an IRWrite found no word available.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH+1) bits: number of queued words.

Function
REQ-015 The queue SHALL be a circular FIFO with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 mem_ready SHALL equal (count != DEPTH) and SHALL depend only on registered state; a pop in the same cycle does not free a slot for a push.
REQ-017 A push SHALL occur when mem_valid && mem_ready && !flush && !bypass: memData is written at tail, tail increments, and count increments unless a pop also occurs.
REQ-018 A pop SHALL occur when IRWrite && count != 0 && !flush: ir <= entry at head, head increments, ir_valid <= 1, and count decrements unless a push also occurs.
REQ-019 A bypass SHALL occur when IRWrite && count == 0 && mem_valid && !flush: ir <= memData, ir_valid <= 1, and no entry is written.
REQ-020 A miss SHALL occur when IRWrite && count == 0 && !mem_valid && !flush: ir holds its value, ir_valid <= 0, and load_miss = 1 for that one cycle.
REQ-021 When no IRWrite occurs, ir and ir_valid SHALL hold their values.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order, including when both pointers wrap in the same cycle.
REQ-023 flush SHALL take priority over all other inputs: head, tail and count <= 0, ir_valid <= 0, and ir holds its value; no push, pop or bypass occurs, and any word presented that cycle is dropped.
REQ-024 Data latency SHALL be as follows: a word pushed at edge N is loadable into ir at edge N+1 or later; a bypassed word appears on ir after 1 edge.
REQ-025 count SHALL never exceed DEPTH and never underflow.
REQ-026 ir_op SHALL be purely combinational from ir.

Reset
REQ-027 While rst_n=0, regardless of clk: head, tail, count = 0; ir = 0; ir_valid = 0; load_miss = 0; mem_ready = 1.
REQ-028 Queue storage contents SHALL need no reset and SHALL never be observable while count == 0.
REQ-029 Deassertion of rst_n SHALL take effect at the first rising clk edge after release; an assertion mid-transfer SHALL abandon that transfer with no partial update.

Verification
REQ-030 The bench SHALL cover in-order fill, WIDTH=16 and DEPTH=4: push 0x1111, 0x2222, 0x3333, 0x4444 -> count=4, mem_ready=0; a fifth word 0x5555 is not accepted; four IRWrites -> ir = 0x1111, then 0x2222, then 0x3333, then 0x4444, with ir_op = 1, 2, 3, 4.
REQ-031 The bench SHALL cover bypass: with the queue empty, drive mem_valid with memData=0xA123 and IRWrite together -> after 1 edge ir = 0xA123, ir_op = 0xA, count = 0.
REQ-032 The bench SHALL cover a miss: with the queue empty, mem_valid=0 and IRWrite=1 -> load_miss = 1 for one cycle, ir_valid = 0, ir unchanged.
REQ-033 The bench SHALL cover simultaneous push and pop with wrap: run 10 or more cycles of continuous push and pop at count=2 -> count stays 2, the output sequence equals the input sequence, and the pointers wrap.
REQ-034 The bench SHALL cover flush priority: with count=3, assert flush together with mem_valid and IRWrite -> count = 0, ir_valid = 0, ir unchanged, and the pushed word is never output.
REQ-035 The bench SHALL cover asynchronous reset: assert rst_n=0 between clock edges at count=3 -> outputs reach their reset values immediately, without waiting for clk; repeat the fill test with WIDTH=32 and DEPTH=8.
